// File: rtl/axi_mem_pkg.sv
// Shared constants and types for the AXI4 read-only memory responder.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

endpackage

// File: rtl/axi_r_skid_fifo.sv
// Two-entry first-word-fall-through FIFO holding packed R-channel beats.
// The head entry sits in a register, so the outputs stay stable while the consumer stalls.
module axi_r_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && (count_q != 2'd2);
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign pop_data = slot_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/axi_mem_read_responder.sv
// AXI4 read-only slave memory: one INCR burst at a time, word-addressed RAM,
// per-beat bounds check and full R-channel backpressure through a 2-entry FIFO.
module axi_mem_read_responder
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [ADDR_WIDTH-1:0]        s_axi_ARADDR,
    input  logic [7:0]                   s_axi_ARLEN,
    input  logic [ID_WIDTH-1:0]          s_axi_ARID,
    input  logic                         s_axi_ARVALID,
    output logic                         s_axi_ARREADY,
    output logic [DATA_WIDTH-1:0]        s_axi_RDATA,
    output logic [ID_WIDTH-1:0]          s_axi_RID,
    output logic [1:0]                   s_axi_RRESP,
    output logic                         s_axi_RLAST,
    output logic                         s_axi_RVALID,
    input  logic                         s_axi_RREADY,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data
);

    localparam int MEM_AW  = $clog2(MEM_DEPTH);
    localparam int OFFS    = $clog2(DATA_WIDTH / 8);
    localparam int ENTRY_W = DATA_WIDTH + ID_WIDTH + 3;

    state_e                  state_q, state_d;
    logic                    arready_q, arready_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [8:0]              cnt_q, cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0]   rd_word_q;

    logic                    ar_hs;
    logic                    r_hs;
    logic                    issue;
    logic                    idx_oob;
    logic [2:0]              occupancy;

    logic [DATA_WIDTH-1:0]   beat_data;
    logic [1:0]              beat_resp;
    logic [ENTRY_W-1:0]      push_entry;
    logic [ENTRY_W-1:0]      pop_entry;
    logic [1:0]              fifo_count;
    logic                    fifo_empty;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    assign ar_hs   = s_axi_ARVALID && arready_q;
    assign r_hs    = s_axi_RVALID && s_axi_RREADY;
    assign idx_oob = (idx_q >= ADDR_WIDTH'(MEM_DEPTH));

    // Beats buffered plus the one read in flight, minus the beat leaving this cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b0, rd_valid_q} - {2'b0, r_hs};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            idx_q      <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            idx_q      <= idx_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_err_q   <= rd_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (r_hs && s_axi_RLAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arready_d = (state_d == IDLE);
        issue     = (state_q == BURST) && (cnt_q != 9'd0) && (occupancy < 3'd2);
        idx_d     = idx_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        if (ar_hs) begin
            idx_d = s_axi_ARADDR >> OFFS;
            id_d  = s_axi_ARID;
            cnt_d = {1'b0, s_axi_ARLEN} + 9'd1;
        end else if (issue) begin
            idx_d = idx_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q - 9'd1;
        end
        rd_valid_d = issue;
        rd_last_d  = issue && (cnt_q == 9'd1);
        rd_err_d   = issue && idx_oob;
    end

    // Simple dual-port RAM; a load and a read of the same word in one cycle returns the old word.
    always_ff @(posedge ap_clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (issue && !idx_oob) begin
            rd_word_q <= mem[idx_q[MEM_AW-1:0]];
        end
    end

    assign beat_data  = rd_err_q ? '0 : rd_word_q;
    assign beat_resp  = rd_err_q ? RESP_DECERR : RESP_OKAY;
    assign push_entry = {beat_data, id_q, beat_resp, rd_last_q};

    axi_r_skid_fifo #(
        .WIDTH(ENTRY_W)
    ) u_r_fifo (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .push      (rd_valid_q),
        .push_data (push_entry),
        .pop       (r_hs),
        .pop_data  (pop_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign {s_axi_RDATA, s_axi_RID, s_axi_RRESP, s_axi_RLAST} = pop_entry;
    assign s_axi_RVALID  = !fifo_empty;
    assign s_axi_ARREADY = arready_q;

endmodule

// File: tb/tb_axi_mem_read_responder.sv
// Directed self-checking bench for axi_mem_read_responder: latency, streaming,
// backpressure, bounds, back-to-back bursts and reset in the middle of a burst.
module tb_axi_mem_read_responder;

    logic         ap_clk;
    logic         ap_rst;
    logic [63:0]  s_axi_ARADDR;
    logic [7:0]   s_axi_ARLEN;
    logic [0:0]   s_axi_ARID;
    logic         s_axi_ARVALID;
    logic         s_axi_ARREADY;
    logic [511:0] s_axi_RDATA;
    logic [0:0]   s_axi_RID;
    logic [1:0]   s_axi_RRESP;
    logic         s_axi_RLAST;
    logic         s_axi_RVALID;
    logic         s_axi_RREADY;
    logic         ld_en;
    logic [9:0]   ld_addr;
    logic [511:0] ld_data;

    int           compared;
    int           mismatched;
    int           cyc;

    logic [511:0] shadow   [1024];
    logic [511:0] exp_data [16];
    logic [1:0]   exp_resp [16];

    axi_mem_read_responder dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_axi_ARADDR  (s_axi_ARADDR),
        .s_axi_ARLEN   (s_axi_ARLEN),
        .s_axi_ARID    (s_axi_ARID),
        .s_axi_ARVALID (s_axi_ARVALID),
        .s_axi_ARREADY (s_axi_ARREADY),
        .s_axi_RDATA   (s_axi_RDATA),
        .s_axi_RID     (s_axi_RID),
        .s_axi_RRESP   (s_axi_RRESP),
        .s_axi_RLAST   (s_axi_RLAST),
        .s_axi_RVALID  (s_axi_RVALID),
        .s_axi_RREADY  (s_axi_RREADY),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [511:0] wordPattern(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {16{w}};
    endfunction

    task automatic loadWord(input int idx, input logic [511:0] data);
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = data;
        shadow[idx] = data;
        @(negedge ap_clk);
        ld_en   = 1'b0;
    endtask

    task automatic setExpect(input int start_word, input int n);
        for (int i = 0; i < n; i++) begin
            if (start_word + i >= 1024) begin
                exp_data[i] = '0;
                exp_resp[i] = 2'b11;
            end else begin
                exp_data[i] = shadow[start_word + i];
                exp_resp[i] = 2'b00;
            end
        end
    endtask

    // Presents one AR request and returns the cycle number of the handshake edge.
    task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] len, input logic id, output int hs_cyc);
        int waited;
        s_axi_ARADDR  = addr;
        s_axi_ARLEN   = len;
        s_axi_ARID    = id;
        s_axi_ARVALID = 1'b1;
        waited = 0;
        while (!s_axi_ARREADY && waited < 50) begin
            @(negedge ap_clk);
            waited++;
        end
        if (!s_axi_ARREADY) begin
            checkOutput("ar_accept_timeout", 512'(0), 512'(1));
            s_axi_ARVALID = 1'b0;
            hs_cyc = cyc;
        end else begin
            @(negedge ap_clk);
            s_axi_ARVALID = 1'b0;
            hs_cyc = cyc;
        end
    endtask

    // Receives n beats against exp_data/exp_resp; with rand_ready the master stalls about half the time.
    task automatic collectBurst(input int n, input logic id, input bit rand_ready, output int first_cyc, output int last_cyc);
        int           got;
        int           waited;
        bit           stalled;
        logic [511:0] held_data;
        logic [1:0]   held_resp;
        logic         held_last;
        got       = 0;
        waited    = 0;
        stalled   = 1'b0;
        first_cyc = -1;
        last_cyc  = -1;
        held_data = '0;
        held_resp = 2'b00;
        held_last = 1'b0;
        while (got < n && waited < 400) begin
            if (stalled) begin
                checkOutput("stall_valid", 512'(s_axi_RVALID), 512'(1));
                checkOutput("stall_data", s_axi_RDATA, held_data);
                checkOutput("stall_resp", 512'(s_axi_RRESP), 512'(held_resp));
                checkOutput("stall_last", 512'(s_axi_RLAST), 512'(held_last));
            end
            s_axi_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_axi_RVALID && s_axi_RREADY) begin
                checkOutput("beat_data", s_axi_RDATA, exp_data[got]);
                checkOutput("beat_resp", 512'(s_axi_RRESP), 512'(exp_resp[got]));
                checkOutput("beat_last", 512'(s_axi_RLAST), 512'(got == n - 1));
                checkOutput("beat_id", 512'(s_axi_RID), 512'(id));
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            stalled   = s_axi_RVALID && !s_axi_RREADY;
            held_data = s_axi_RDATA;
            held_resp = s_axi_RRESP;
            held_last = s_axi_RLAST;
            @(negedge ap_clk);
            waited++;
        end
        if (got != n) checkOutput("burst_beat_count", 512'(got), 512'(n));
        s_axi_RREADY = 1'b1;
        checkOutput("arready_after_last", 512'(s_axi_ARREADY), 512'(1));
        checkOutput("rvalid_after_last", 512'(s_axi_RVALID), 512'(0));
    endtask

    initial begin
        int hs;
        int hs2;
        int first_c;
        int last_c;
        compared      = 0;
        mismatched    = 0;
        cyc           = 0;
        ap_rst        = 1'b1;
        s_axi_ARADDR  = '0;
        s_axi_ARLEN   = '0;
        s_axi_ARID    = '0;
        s_axi_ARVALID = 1'b0;
        s_axi_RREADY  = 1'b1;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;

        #2;
        checkOutput("rst_arready", 512'(s_axi_ARREADY), 512'(0));
        checkOutput("rst_rvalid", 512'(s_axi_RVALID), 512'(0));
        checkOutput("rst_rlast", 512'(s_axi_RLAST), 512'(0));
        checkOutput("rst_rdata", s_axi_RDATA, 512'(0));
        checkOutput("rst_rid", 512'(s_axi_RID), 512'(0));
        checkOutput("rst_rresp", 512'(s_axi_RRESP), 512'(0));

        @(negedge ap_clk);
        for (int i = 0; i < 24; i++) begin
            if (i == 5) loadWord(i, {64{8'hA5}});
            else        loadWord(i, wordPattern(i));
        end
        loadWord(1022, wordPattern(1022));
        loadWord(1023, wordPattern(1023));

        ap_rst = 1'b0;
        #1;
        checkOutput("arready_before_edge", 512'(s_axi_ARREADY), 512'(0));
        @(negedge ap_clk);
        checkOutput("arready_after_edge", 512'(s_axi_ARREADY), 512'(1));

        $display("[TB] single beat at word 5");
        setExpect(5, 1);
        applyStimulus(64'h140, 8'd0, 1'b1, hs);
        collectBurst(1, 1'b1, 1'b0, first_c, last_c);
        checkOutput("single_latency", 512'(first_c - hs), 512'(2));

        $display("[TB] 16-beat burst at word 0");
        setExpect(0, 16);
        applyStimulus(64'h0, 8'd15, 1'b0, hs);
        collectBurst(16, 1'b0, 1'b0, first_c, last_c);
        checkOutput("burst16_latency", 512'(first_c - hs), 512'(2));
        checkOutput("burst16_no_bubbles", 512'(last_c - first_c), 512'(15));

        $display("[TB] 8-beat burst with random backpressure");
        setExpect(16, 8);
        applyStimulus(64'(16 * 64), 8'd7, 1'b1, hs);
        collectBurst(8, 1'b1, 1'b1, first_c, last_c);

        $display("[TB] burst crossing the end of memory");
        setExpect(1022, 4);
        applyStimulus(64'(1022 * 64), 8'd3, 1'b0, hs);
        collectBurst(4, 1'b0, 1'b0, first_c, last_c);

        $display("[TB] back-to-back bursts");
        setExpect(0, 4);
        applyStimulus(64'h0, 8'd3, 1'b0, hs);
        s_axi_ARADDR  = 64'(10 * 64);
        s_axi_ARLEN   = 8'd1;
        s_axi_ARID    = 1'b1;
        s_axi_ARVALID = 1'b1;
        collectBurst(4, 1'b0, 1'b0, first_c, last_c);
        @(negedge ap_clk);
        s_axi_ARVALID = 1'b0;
        hs2 = cyc;
        checkOutput("b2b_accepted", 512'(s_axi_ARREADY), 512'(0));
        checkOutput("b2b_accept_cycle", 512'(hs2 - last_c), 512'(2));
        setExpect(10, 2);
        collectBurst(2, 1'b1, 1'b0, first_c, last_c);
        checkOutput("b2b_latency", 512'(first_c - hs2), 512'(2));

        $display("[TB] reset in the middle of a burst");
        applyStimulus(64'(8 * 64), 8'd7, 1'b0, hs);
        s_axi_RREADY = 1'b1;
        repeat (4) @(negedge ap_clk);
        checkOutput("midrst_beat3_valid", 512'(s_axi_RVALID), 512'(1));
        checkOutput("midrst_beat3_data", s_axi_RDATA, shadow[10]);
        ap_rst = 1'b1;
        #1;
        checkOutput("midrst_rvalid", 512'(s_axi_RVALID), 512'(0));
        checkOutput("midrst_arready", 512'(s_axi_ARREADY), 512'(0));
        checkOutput("midrst_rdata", s_axi_RDATA, 512'(0));
        checkOutput("midrst_rlast", 512'(s_axi_RLAST), 512'(0));
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checkOutput("midrst_arready_back", 512'(s_axi_ARREADY), 512'(1));
        checkOutput("midrst_fifo_empty", 512'(s_axi_RVALID), 512'(0));
        setExpect(20, 2);
        applyStimulus(64'(20 * 64), 8'd1, 1'b1, hs);
        collectBurst(2, 1'b1, 1'b0, first_c, last_c);
        checkOutput("post_rst_latency", 512'(first_c - hs), 512'(2));

        repeat (3) @(negedge ap_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_mem_read_responder.md
# axi_mem_read_responder

AXI4 read-only slave memory that answers the kernel's gmem read master (the read side of a `gmem` port). It accepts one INCR burst at a time on AR, streams beats back on R from an internal word-addressed memory, and supports full R-channel backpressure. Contents are written through a simple load port. The block is used as the on-chip or bench-side memory behind the distance kernel's read ports.

## Interface
- DATA_WIDTH, 512: R data width in bits; a power of two, at least 32.
- ADDR_WIDTH, 64: AR address width.
- ID_WIDTH, 1: ARID/RID width.
- MEM_DEPTH, 1024: number of DATA_WIDTH-bit words; a power of two.

Ports:
- ap_clk  in  1  single clock.
- ap_rst  in  1  asynchronous, active-high reset.
- s_axi_ARADDR  in  ADDR_WIDTH  byte address of the first beat.
- s_axi_ARLEN  in  8  beats minus 1.
- s_axi_ARID  in  ID_WIDTH  transaction ID.
- s_axi_ARVALID  in  1  address valid.
- s_axi_ARREADY  out  1  address accepted.
- s_axi_RDATA  out  DATA_WIDTH  beat data.
- s_axi_RID  out  ID_WIDTH  echo of the latched ARID.
- s_axi_RRESP  out  2  2'b00 OKAY; 2'b11 DECERR.
- s_axi_RLAST  out  1  final beat of the burst.
- s_axi_RVALID  out  1  beat valid.
- s_axi_RREADY  in  1  master accepts the beat.
- ld_en  in  1  memory write strobe.
- ld_addr  in  $clog2(MEM_DEPTH)  word index.
- ld_data  in  DATA_WIDTH  word written.

## Operation
- Only INCR bursts of full-width beats are supported. ARSIZE and ARBURST are not ports.
- Word index = ARADDR >> log2(DATA_WIDTH/8). Low address bits are ignored, so unaligned addresses are aligned down.
- The FSM has two states:
  - IDLE: ARREADY=1. On ARVALID&&ARREADY, latch the word index, ID and beat count (ARLEN+1), then go to BURST.
  - BURST: ARREADY=0. Issue one memory read per cycle whenever the output buffer has space. Increment the read index; decrement the issue counter.
  - BURST -> IDLE when the R handshake completes with RLAST=1.
- The output buffer is a 2-entry FIFO. It absorbs the one-cycle memory read latency so that deasserting RREADY never loses a beat.
- Per-beat bounds check: if the word index is >= MEM_DEPTH, that beat has RRESP=DECERR and RDATA=0, and the burst still completes. Indices never wrap inside the memory.
- The 4 KB boundary is not checked.
- RLAST=1 only on beat ARLEN+1. ARLEN=0 gives a single beat with RLAST=1.
- RDATA, RID, RRESP and RLAST hold stable while RVALID=1 and RREADY=0.
- Load port: writes memory on any cycle, including during a burst. A same-cycle read and load of the same index returns the old data.
- Memory contents are not reset.

## Timing
- Reset values (async, immediate): ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=0; FSM in IDLE; FIFO empty.
- ARREADY rises on the first ap_clk edge after ap_rst deasserts.
- AR handshake at cycle T: the first RVALID is at T+2.
- With RREADY held high, throughput is one beat per cycle with no bubbles.
- Last-beat handshake at cycle L: ARREADY=1 at L+1. An ARVALID already pending is accepted at L+1.
- RREADY low for N cycles stalls the burst for exactly N cycles. No beat is lost or duplicated.
- ap_rst asserted mid-burst: the burst is abandoned. RVALID falls asynchronously and the FIFO and counters clear.
- ARVALID while in BURST is ignored (ARREADY=0); the address must be held by the master.

## Structure
- Package axi_mem_pkg holds:
  - RESP_OKAY=2'b00 and RESP_DECERR=2'b11;
  - the state enum {IDLE, BURST}.
- Sub-module axi_r_skid_fifo: a 2-deep first-word-fall-through FIFO carrying {RDATA, RID, RRESP, RLAST}, with count-based full/empty on ap_clk/ap_rst.
- The memory is an inferred simple-dual-port RAM inside the top level.

## Test plan
- Reset then single beat: preload word 5 = 0xA5 repeated; AR ARADDR=0x140, ARLEN=0, ARID=1 -> one beat with RDATA=0xA5…, RID=1, RRESP=0, RLAST=1, RVALID exactly two cycles after the AR handshake.
- 16-beat burst at word 0 with RREADY high -> data equals words 0..15, 16 consecutive RVALID cycles, RLAST only on beat 16, ARREADY=1 the cycle after.
- Backpressure: 8-beat burst with RREADY random at 50% -> all 8 beats in order with no loss or duplication, and outputs stable while stalled.
- Bounds: MEM_DEPTH=1024, ARADDR word index 1022, ARLEN=3 -> beats 1–2 OKAY with data, beats 3–4 DECERR with RDATA=0, burst completes with RLAST.
- Back-to-back: second ARVALID held during the first burst -> accepted one cycle after the first RLAST handshake, with the correct RID per burst.
- Reset mid-burst: assert ap_rst at beat 3 of 8 -> RVALID=0 immediately; after release a new 2-beat burst returns the correct data.
